// File: rtl/code_sender_pkg.sv
// Shared definitions for the colour-code sender and detector benches:
// symbol encodings, FSM state encodings and a small constant helper.
package code_sender_pkg;

   typedef enum logic [1:0] {
      SYM_END   = 2'b00,
      SYM_RED   = 2'b01,
      SYM_BLUE  = 2'b10,
      SYM_GREEN = 2'b11
   } symbolT;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      SYM   = 3'd2,
      GAP   = 3'd3,
      DONE  = 3'd4
   } stateT;

   function automatic int maxOf(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/code_sender_if.sv
// Request/line bundle between a code sender and its user.
// Optional unlock-check signals U/Pass exist only with CODE_SENDER_CHECK_EN.
interface code_sender_if #(parameter int CODE_LEN = 4) ();

   logic                  Go;
   logic [2*CODE_LEN-1:0] Code;
   logic                  Start;
   logic                  Red;
   logic                  Green;
   logic                  Blue;
   logic                  Busy;
   logic                  Done;
`ifdef CODE_SENDER_CHECK_EN
   logic                  U;
   logic                  Pass;

   modport master (output Go, Code, U,
                   input  Start, Red, Green, Blue, Busy, Done, Pass);
   modport slave  (input  Go, Code, U,
                   output Start, Red, Green, Blue, Busy, Done, Pass);
`else
   modport master (output Go, Code,
                   input  Start, Red, Green, Blue, Busy, Done);
   modport slave  (input  Go, Code,
                   output Start, Red, Green, Blue, Busy, Done);
`endif

endinterface

// File: rtl/code_phase_timer.sv
// Loadable down-counter that stops at zero; times both hold and gap phases.
module code_phase_timer #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_i,
   input  logic [WIDTH-1:0] loadValue_i,
   output logic             zero_o
);

   logic [WIDTH-1:0] countQ;
   logic [WIDTH-1:0] countD;

   always_comb begin
      countD = countQ;
      if (load_i) begin
         countD = loadValue_i;
      end else if (countQ != '0) begin
         countD = countQ - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         countQ <= '0;
      end else begin
         countQ <= countD;
      end
   end

   assign zero_o = (countQ == '0);

endmodule

// File: rtl/code_sender.sv
// Replays a latched colour code as Start + symbol pulses separated by gaps.
// Define CODE_SENDER_CHECK_EN to add the U input and the Pass result flag.
module code_sender
   import code_sender_pkg::*;
#(
   parameter int CODE_LEN    = 4,
   parameter int HOLD_CYCLES = 1,
   parameter int GAP_CYCLES  = 1
) (
   input  logic           Clk,
   input  logic           Rst,
   code_sender_if.slave   link
);

   localparam int TIMER_W = $clog2(maxOf(HOLD_CYCLES, GAP_CYCLES) + 1);
   localparam int IDX_W   = $clog2(CODE_LEN + 1);
   localparam logic [TIMER_W-1:0] HOLD_LOAD = TIMER_W'(HOLD_CYCLES - 1);
   localparam logic [TIMER_W-1:0] GAP_LOAD  = TIMER_W'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(CODE_LEN);

   stateT                 stateQ, stateD;
   logic [2*CODE_LEN-1:0] codeQ, codeD;
   logic [IDX_W-1:0]      idxQ, idxD;
   logic                  startQ, startD;
   logic                  redQ, redD;
   logic                  greenQ, greenD;
   logic                  blueQ, blueD;
   logic                  busyQ, busyD;
   logic                  doneQ, doneD;
   logic                  timerLoad;
   logic [TIMER_W-1:0]    timerLoadValue;
   logic                  timerZero;
   logic                  nextAvail;

   // Out-of-range indices read as the end marker.
   function automatic symbolT symbolAt(input logic [2*CODE_LEN-1:0] code,
                                       input logic [IDX_W-1:0]      i);
      symbolAt = SYM_END;
      for (int k = 0; k < CODE_LEN; k++) begin
         if (IDX_W'(k) == i) begin
            symbolAt = symbolT'(code[2*k +: 2]);
         end
      end
   endfunction

   // idxQ already points past the symbol just sent, so it names the candidate.
   assign nextAvail = (idxQ < LAST_IDX) && (symbolAt(codeQ, idxQ) != SYM_END);

   code_phase_timer #(.WIDTH(TIMER_W)) phaseTimer (
      .clk         (Clk),
      .rst         (Rst),
      .load_i      (timerLoad),
      .loadValue_i (timerLoadValue),
      .zero_o      (timerZero)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         stateQ <= IDLE;
         codeQ  <= '0;
         idxQ   <= '0;
         startQ <= 1'b0;
         redQ   <= 1'b0;
         greenQ <= 1'b0;
         blueQ  <= 1'b0;
         busyQ  <= 1'b0;
         doneQ  <= 1'b0;
      end else begin
         stateQ <= stateD;
         codeQ  <= codeD;
         idxQ   <= idxD;
         startQ <= startD;
         redQ   <= redD;
         greenQ <= greenD;
         blueQ  <= blueD;
         busyQ  <= busyD;
         doneQ  <= doneD;
      end
   end

   always_comb begin
      stateD = stateQ;
      codeD  = codeQ;
      idxD   = idxQ;
      case (stateQ)
         IDLE: begin
            if (link.Go) begin
               stateD = START;
               codeD  = link.Code;
               idxD   = '0;
            end
         end
         START: begin
            if (timerZero) stateD = GAP;
         end
         SYM: begin
            if (timerZero) begin
               stateD = GAP;
               idxD   = idxQ + 1'b1;
            end
         end
         GAP: begin
            if (timerZero) stateD = nextAvail ? SYM : DONE;
         end
         DONE: stateD = IDLE;
         default: stateD = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so the registered lines line up
   // with the state they belong to; the timer reloads on every state change.
   always_comb begin
      startD         = 1'b0;
      redD           = 1'b0;
      greenD         = 1'b0;
      blueD          = 1'b0;
      busyD          = (stateD != IDLE);
      doneD          = (stateD == DONE);
      timerLoad      = (stateD != stateQ);
      timerLoadValue = '0;
      case (stateD)
         START: begin
            startD         = 1'b1;
            timerLoadValue = HOLD_LOAD;
         end
         SYM: begin
            timerLoadValue = HOLD_LOAD;
            case (symbolAt(codeQ, idxD))
               SYM_RED:   redD   = 1'b1;
               SYM_GREEN: greenD = 1'b1;
               SYM_BLUE:  blueD  = 1'b1;
               default:   ;
            endcase
         end
         GAP: timerLoadValue = GAP_LOAD;
         default: ;
      endcase
   end

   assign link.Start = startQ;
   assign link.Red   = redQ;
   assign link.Green = greenQ;
   assign link.Blue  = blueQ;
   assign link.Busy  = busyQ;
   assign link.Done  = doneQ;

`ifdef CODE_SENDER_CHECK_EN
   logic passQ, passD;
   logic finalWindow;

   // The final gap is the one whose exit goes to DONE.
   assign finalWindow = ((stateQ == GAP) && !nextAvail) || (stateQ == DONE);

   always_comb begin
      passD = passQ;
      if ((stateQ == IDLE) && link.Go) begin
         passD = 1'b0;
      end else if (finalWindow && link.U) begin
         passD = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         passQ <= 1'b0;
      end else begin
         passQ <= passD;
      end
   end

   assign link.Pass = passQ;
`endif

endmodule

// File: tb/tb_code_sender.sv
// Directed bench for code_sender: default timing, early end marker, long
// hold/gap timing, Go held with Code changes, mid-sequence reset, Pass flag.
module tb_code_sender;
   import code_sender_pkg::*;

   logic clock;
   logic reset;
   int   checks;
   int   failures;

   code_sender_if #(.CODE_LEN(4)) busA ();
   code_sender_if #(.CODE_LEN(4)) busB ();

   code_sender #(.CODE_LEN(4), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dutA (
      .Clk  (clock),
      .Rst  (reset),
      .link (busA.slave)
   );

   code_sender #(.CODE_LEN(4), .HOLD_CYCLES(3), .GAP_CYCLES(2)) dutB (
      .Clk  (clock),
      .Rst  (reset),
      .link (busB.slave)
   );

   logic [5:0] vecA;
   logic [5:0] vecB;
   assign vecA = {busA.Start, busA.Red, busA.Green, busA.Blue, busA.Busy, busA.Done};
   assign vecB = {busB.Start, busB.Red, busB.Green, busB.Blue, busB.Busy, busB.Done};

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input bit sel, input logic go, input logic [7:0] code);
      if (sel) begin
         busB.Go   = go;
         busB.Code = code;
      end else begin
         busA.Go   = go;
         busA.Code = code;
      end
   endtask

   // Expected {Start,Red,Green,Blue,Busy,Done} in cycle c after Go was sampled.
   function automatic logic [5:0] expectedVec(input int c, input logic [7:0] code,
                                              input int nSym, input int hold, input int gap);
      int period;
      int total;
      int p;
      logic [1:0] s;
      period = hold + gap;
      total  = (nSym + 1) * period;
      expectedVec = '0;
      if (c >= 1 && c <= total) begin
         expectedVec[1] = 1'b1;
         p = (c - 1) / period;
         if ((c - 1) % period < hold) begin
            if (p == 0) begin
               expectedVec[5] = 1'b1;
            end else begin
               s = code[2*(p-1) +: 2];
               case (s)
                  2'b01:   expectedVec[4] = 1'b1;
                  2'b11:   expectedVec[3] = 1'b1;
                  2'b10:   expectedVec[2] = 1'b1;
                  default: ;
               endcase
            end
         end
      end else if (c == total + 1) begin
         expectedVec[1:0] = 2'b11;
      end
   endfunction

   // Call at a negedge; pulses Go for one cycle and checks through one idle cycle.
   task automatic runSequence(input string tag, input bit sel, input logic [7:0] code,
                              input int nSym, input int hold, input int gap);
      int total;
      logic [5:0] v;
      total = (nSym + 1) * (hold + gap) + 2;
      applyStimulus(sel, 1'b1, code);
      for (int c = 1; c <= total; c++) begin
         @(negedge clock);
         v = sel ? vecB : vecA;
         checkOutput($sformatf("%s c%0d", tag, c), 32'(v), 32'(expectedVec(c, code, nSym, hold, gap)));
         checkOutput($sformatf("%s onehot c%0d", tag, c), 32'($countones(v[5:2]) <= 1), 32'd1);
         if (c == 1) applyStimulus(sel, 1'b0, 8'h00);
      end
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      applyStimulus(1'b0, 1'b0, 8'h00);
      applyStimulus(1'b1, 1'b0, 8'h00);
`ifdef CODE_SENDER_CHECK_EN
      busA.U = 1'b0;
      busB.U = 1'b0;
`endif
      repeat (3) @(negedge clock);
      checkOutput("reset A", 32'(vecA), 32'd0);
      checkOutput("reset B", 32'(vecB), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      checkOutput("idle A", 32'(vecA), 32'd0);

      $display("[TB] full code R,B,G,R with default timing");
      runSequence("rbgr", 1'b0, 8'b01_11_10_01, 4, 1, 1);

      $display("[TB] end marker after two symbols");
      runSequence("rb", 1'b0, 8'b00_00_10_01, 2, 1, 1);

      $display("[TB] hold 3 gap 2");
      runSequence("long", 1'b1, 8'b01_11_10_01, 4, 3, 2);

      $display("[TB] first symbol is end marker");
      runSequence("empty", 1'b0, 8'b01_01_01_00, 0, 1, 1);

      $display("[TB] Go held high, Code changed while busy");
      applyStimulus(1'b0, 1'b1, 8'b00_00_10_01);
      for (int c = 1; c <= 21; c++) begin
         @(negedge clock);
         if (c <= 8)
            checkOutput($sformatf("held c%0d", c), 32'(vecA), 32'(expectedVec(c, 8'b00_00_10_01, 2, 1, 1)));
         else
            checkOutput($sformatf("held c%0d", c), 32'(vecA), 32'(expectedVec(c - 8, 8'b01_01_01_01, 4, 1, 1)));
         if (c == 3) applyStimulus(1'b0, 1'b1, 8'b01_01_01_01);
         if (c == 9) applyStimulus(1'b0, 1'b0, 8'b11_11_11_11);
      end

      $display("[TB] reset during Blue hold");
      applyStimulus(1'b0, 1'b1, 8'b01_11_10_01);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clock);
         if (c <= 5)
            checkOutput($sformatf("abort c%0d", c), 32'(vecA), 32'(expectedVec(c, 8'b01_11_10_01, 4, 1, 1)));
         else
            checkOutput($sformatf("abort c%0d", c), 32'(vecA), 32'd0);
         if (c == 1) applyStimulus(1'b0, 1'b0, 8'h00);
         if (c == 5) reset = 1'b1;
         if (c == 6) reset = 1'b0;
      end
      runSequence("restart", 1'b0, 8'b01_11_10_01, 4, 1, 1);

`ifdef CODE_SENDER_CHECK_EN
      $display("[TB] unlock check flag");
      applyStimulus(1'b0, 1'b1, 8'b01_11_10_01);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clock);
         if (c == 1) applyStimulus(1'b0, 1'b0, 8'h00);
         if (c == 2) checkOutput("pass low early", 32'(busA.Pass), 32'd0);
         if (c == 11) checkOutput("pass before done edge", 32'(busA.Pass), 32'd1);
         if (c == 12) checkOutput("pass set", 32'(busA.Pass), 32'd1);
         busA.U = (c == 10);
      end
      applyStimulus(1'b0, 1'b1, 8'b01_10_11_01);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clock);
         if (c == 1) applyStimulus(1'b0, 1'b0, 8'h00);
         if (c == 2) checkOutput("pass cleared", 32'(busA.Pass), 32'd0);
         if (c == 12) checkOutput("pass stays low", 32'(busA.Pass), 32'd0);
         busA.U = (c == 4);
      end
      busA.U = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
